// File: rtl/bin2dec_display.sv
// Signed binary to sign-magnitude BCD converter for the calculator display.
// Sequential double-dabble: one magnitude bit per clock, leading-zero blanking on the result.

module bin2dec_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2dec_display #(
  parameter int DATA_W    = 16,
  parameter int DIGITS    = 5,
  parameter int SIGNED_IN = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  start,
  input  logic [DATA_W-1:0]     value_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sign_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // The largest magnitude (2^(DATA_W-1) for signed input) must fit in DIGITS decimal digits.
  if (pow10(DIGITS) <= (longint'(1) << (DATA_W - 1))) begin : g_bad_digits
    $error("bin2dec_display: DIGITS too small for DATA_W");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mag;
  logic [BW-1:0]     scratch, scratch_adj;
  logic [CW-1:0]     cnt;
  logic              sign_l;
  logic [DIGITS-1:0] en_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin2dec_add3 u_add3 (.d(scratch[4*g +: 4]), .q(scratch_adj[4*g +: 4]));
  end

  always_comb begin
    en_nxt = '0;
    for (int k = 0; k < DIGITS; k++) en_nxt[k] = |(scratch >> (4 * k));
    en_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      mag      <= '0;
      scratch  <= '0;
      cnt      <= '0;
      sign_l   <= 1'b0;
      done     <= 1'b0;
      sign_out <= 1'b0;
      bcd_out  <= '0;
      digit_en <= DIGITS'(1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // 2's-complement negate of the most negative value wraps to itself, which is its unsigned magnitude.
          mag     <= (value_in[DATA_W-1] && SIGNED_IN != 0) ? (~value_in + 1'b1) : value_in;
          sign_l  <= value_in[DATA_W-1] && SIGNED_IN != 0;
          scratch <= '0;
          cnt     <= CW'(DATA_W);
        end
        SHIFT: begin
          {scratch, mag} <= {scratch_adj[BW-2:0], mag, 1'b0};
          cnt            <= cnt - 1'b1;
        end
        FINISH: begin
          bcd_out  <= scratch;
          sign_out <= sign_l && (scratch != '0);
          digit_en <= en_nxt;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2dec_display.sv
// Directed bench for bin2dec_display: reset, conversions, extremes and start/done handshake.

module tb_bin2dec_display;
  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value_in = '0;
  logic        busy, done, sign_out;
  logic [19:0] bcd_out;
  logic [4:0]  digit_en;

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] last_bcd = '0;

  bin2dec_display #(.DATA_W(16), .DIGITS(5), .SIGNED_IN(1)) dut (
    .clk(clk), .RST(RST), .start(start), .value_in(value_in),
    .busy(busy), .done(done), .sign_out(sign_out),
    .bcd_out(bcd_out), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input logic [19:0] exp_bcd,
                         input logic exp_sign, input logic [4:0] exp_en);
    int  n;
    bit  got;
    @(negedge clk);
    value_in = v;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    value_in = ~v;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      // a stray start mid-conversion must be ignored
      if (n == 5) begin start = 1'b1; value_in = 16'h1111; end
      else start = 1'b0;
      if (n == 8) chk({tag, " hold"}, 32'(bcd_out), 32'(last_bcd));
      if (done) got = 1;
    end
    chk({tag, " latency"}, n, 17);
    chk({tag, " bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({tag, " sign"}, 32'(sign_out), 32'(exp_sign));
    chk({tag, " en"}, 32'(digit_en), 32'(exp_en));
    @(posedge clk); #1;
    chk({tag, " done1"}, 32'(done), 32'd0);
    last_bcd = exp_bcd;
  endtask

  initial begin
    int dn;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sign", 32'(sign_out), 32'd0);
    chk("rst bcd", 32'(bcd_out), 32'd0);
    chk("rst en", 32'(digit_en), 32'd1);
    @(negedge clk); RST = 1'b0;

    convert("p3345", 16'd3345, 20'h03345, 1'b0, 5'b01111);

    // reset mid-conversion
    @(negedge clk); value_in = 16'd1234; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; RST = 1'b1; #1;
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid done", 32'(done), 32'd0);
    chk("mid bcd", 32'(bcd_out), 32'd0);
    chk("mid en", 32'(digit_en), 32'd1);
    @(negedge clk); RST = 1'b0;
    last_bcd = '0;
    dn = 0;
    repeat (25) begin @(posedge clk); #1; if (done) dn++; end
    chk("mid nodone", dn, 0);

    convert("n8000", 16'h8000, 20'h32768, 1'b1, 5'b11111);
    convert("nffff", 16'hFFFF, 20'h00001, 1'b1, 5'b00001);
    convert("zero", 16'h0000, 20'h00000, 1'b0, 5'b00001);
    convert("n99", 16'hFF9D, 20'h00099, 1'b1, 5'b00011);
    convert("p9", 16'd9, 20'h00009, 1'b0, 5'b00001);

    // start held high, value alternates; accepted edges 0,18,36,54 all see -99
    @(negedge clk); start = 1'b1; value_in = 16'hFF9D;
    for (int c = 0; c <= 56; c++) begin
      @(posedge clk); #1;
      value_in = (((c + 1) % 2) == 0) ? 16'hFF9D : 16'd99;
      chk($sformatf("hs done c%0d", c), 32'(done), 32'(c == 17 || c == 35 || c == 53));
      if (c == 17 || c == 35 || c == 53) begin
        chk($sformatf("hs bcd c%0d", c), 32'(bcd_out), 32'h00099);
        chk($sformatf("hs sign c%0d", c), 32'(sign_out), 32'd1);
        chk($sformatf("hs en c%0d", c), 32'(digit_en), 32'b00011);
      end
    end
    start = 1'b0;
    repeat (25) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
